// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 7-segment display path: segment patterns,
// digit codes, anode selects and the capture FSM state type.
package sevenseg_pkg;

    // Segment patterns, active-high, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] PAT_0     = 7'h3F;
    localparam logic [6:0] PAT_1     = 7'h06;
    localparam logic [6:0] PAT_2     = 7'h5B;
    localparam logic [6:0] PAT_3     = 7'h4F;
    localparam logic [6:0] PAT_4     = 7'h66;
    localparam logic [6:0] PAT_5     = 7'h6D;
    localparam logic [6:0] PAT_6     = 7'h7D;
    localparam logic [6:0] PAT_7     = 7'h07;
    localparam logic [6:0] PAT_8     = 7'h7F;
    localparam logic [6:0] PAT_9     = 7'h6F;
    localparam logic [6:0] PAT_A     = 7'h77;
    localparam logic [6:0] PAT_B     = 7'h7C;
    localparam logic [6:0] PAT_C     = 7'h39;
    localparam logic [6:0] PAT_D     = 7'h5E;
    localparam logic [6:0] PAT_E     = 7'h79;
    localparam logic [6:0] PAT_F     = 7'h71;
    localparam logic [6:0] PAT_SEG_A = 7'h01;
    localparam logic [6:0] PAT_SEG_B = 7'h02;
    localparam logic [6:0] PAT_SEG_C = 7'h04;
    localparam logic [6:0] PAT_SEG_D = 7'h08;
    localparam logic [6:0] PAT_SEG_E = 7'h10;
    localparam logic [6:0] PAT_SEG_F = 7'h20;
    localparam logic [6:0] PAT_SEG_G = 7'h40;
    localparam logic [6:0] PAT_BLANK = 7'h00;
    localparam logic [6:0] PAT_H     = 7'h76;
    localparam logic [6:0] PAT_L     = 7'h38;
    localparam logic [6:0] PAT_R_LC  = 7'h50;
    localparam logic [6:0] PAT_N_LC  = 7'h54;
    // Glyphs that share a pattern with another symbol; they decode to the lower code
    localparam logic [6:0] PAT_R     = PAT_A;
    localparam logic [6:0] PAT_G_LC  = PAT_9;

    // Digit codes that carry special meaning
    localparam logic [4:0] CODE_SEG_A   = 5'd16;
    localparam logic [4:0] CODE_BLANK   = 5'd23;
    localparam logic [4:0] CODE_H       = 5'd24;
    localparam logic [4:0] CODE_L       = 5'd25;
    localparam logic [4:0] CODE_R_LC    = 5'd28;
    localparam logic [4:0] CODE_N_LC    = 5'd29;
    localparam logic [4:0] CODE_UNKNOWN = 5'd31;

    // One-hot-low anode selects, bit0 = digit0
    localparam logic [7:0] AN_DIGIT0 = 8'hFE;
    localparam logic [7:0] AN_DIGIT1 = 8'hFD;
    localparam logic [7:0] AN_DIGIT2 = 8'hFB;
    localparam logic [7:0] AN_DIGIT3 = 8'hF7;
    localparam logic [7:0] AN_DIGIT4 = 8'hEF;
    localparam logic [7:0] AN_DIGIT5 = 8'hDF;
    localparam logic [7:0] AN_DIGIT6 = 8'hBF;
    localparam logic [7:0] AN_DIGIT7 = 8'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } cap_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } anode_decode_t;

    // Anything other than exactly one low anode bit is not a legal digit select
    function automatic anode_decode_t decode_anode(input logic [7:0] an);
        anode_decode_t d;
        d.valid = 1'b1;
        d.idx   = 3'd0;
        case (an)
            AN_DIGIT0: d.idx = 3'd0;
            AN_DIGIT1: d.idx = 3'd1;
            AN_DIGIT2: d.idx = 3'd2;
            AN_DIGIT3: d.idx = 3'd3;
            AN_DIGIT4: d.idx = 3'd4;
            AN_DIGIT5: d.idx = 3'd5;
            AN_DIGIT6: d.idx = 3'd6;
            AN_DIGIT7: d.idx = 3'd7;
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sevenseg_capture_if.sv
// Display-line bundle between the multiplexed display driver (master)
// and the capture block (slave) that reconstructs the frame.
interface sevenseg_capture_if;
    logic [7:0]  an_in;
    logic [7:0]  seg_in;
    logic [39:0] digits_out;
    logic [7:0]  dp_out;
    logic [7:0]  unknown;
    logic        frame_valid;
    logic        err_seq;
    logic        stalled;

    modport master (
        output an_in,
        output seg_in,
        input  digits_out,
        input  dp_out,
        input  unknown,
        input  frame_valid,
        input  err_seq,
        input  stalled
    );

    modport slave (
        input  an_in,
        input  seg_in,
        output digits_out,
        output dp_out,
        output unknown,
        output frame_valid,
        output err_seq,
        output stalled
    );
endinterface

// File: rtl/seg_pattern_decode.sv
// Maps an active-high 7-segment pattern back to its 5-bit digit code.
// Unrecognised patterns give CODE_UNKNOWN and raise o_unknown.
module seg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [4:0] o_code,
    output logic       o_unknown
);

    // Pattern lookup; aliased glyphs (R, g) fall onto A and 9 automatically
    always_comb begin
        o_code    = CODE_UNKNOWN;
        o_unknown = 1'b1;
        case (i_pattern)
            PAT_0:     begin o_code = 5'd0;  o_unknown = 1'b0; end
            PAT_1:     begin o_code = 5'd1;  o_unknown = 1'b0; end
            PAT_2:     begin o_code = 5'd2;  o_unknown = 1'b0; end
            PAT_3:     begin o_code = 5'd3;  o_unknown = 1'b0; end
            PAT_4:     begin o_code = 5'd4;  o_unknown = 1'b0; end
            PAT_5:     begin o_code = 5'd5;  o_unknown = 1'b0; end
            PAT_6:     begin o_code = 5'd6;  o_unknown = 1'b0; end
            PAT_7:     begin o_code = 5'd7;  o_unknown = 1'b0; end
            PAT_8:     begin o_code = 5'd8;  o_unknown = 1'b0; end
            PAT_9:     begin o_code = 5'd9;  o_unknown = 1'b0; end
            PAT_A:     begin o_code = 5'd10; o_unknown = 1'b0; end
            PAT_B:     begin o_code = 5'd11; o_unknown = 1'b0; end
            PAT_C:     begin o_code = 5'd12; o_unknown = 1'b0; end
            PAT_D:     begin o_code = 5'd13; o_unknown = 1'b0; end
            PAT_E:     begin o_code = 5'd14; o_unknown = 1'b0; end
            PAT_F:     begin o_code = 5'd15; o_unknown = 1'b0; end
            PAT_SEG_A: begin o_code = CODE_SEG_A;         o_unknown = 1'b0; end
            PAT_SEG_B: begin o_code = CODE_SEG_A + 5'd1;  o_unknown = 1'b0; end
            PAT_SEG_C: begin o_code = CODE_SEG_A + 5'd2;  o_unknown = 1'b0; end
            PAT_SEG_D: begin o_code = CODE_SEG_A + 5'd3;  o_unknown = 1'b0; end
            PAT_SEG_E: begin o_code = CODE_SEG_A + 5'd4;  o_unknown = 1'b0; end
            PAT_SEG_F: begin o_code = CODE_SEG_A + 5'd5;  o_unknown = 1'b0; end
            PAT_SEG_G: begin o_code = CODE_SEG_A + 5'd6;  o_unknown = 1'b0; end
            PAT_BLANK: begin o_code = CODE_BLANK; o_unknown = 1'b0; end
            PAT_H:     begin o_code = CODE_H;     o_unknown = 1'b0; end
            PAT_L:     begin o_code = CODE_L;     o_unknown = 1'b0; end
            PAT_R_LC:  begin o_code = CODE_R_LC;  o_unknown = 1'b0; end
            PAT_N_LC:  begin o_code = CODE_N_LC;  o_unknown = 1'b0; end
            default:   begin o_code = CODE_UNKNOWN; o_unknown = 1'b1; end
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Watches the multiplexed anode/cathode lines of an 8-digit display and
// rebuilds the displayed frame. A digit is sampled once its anode has been
// stable long enough for the cathodes to settle; a full in-order scan from
// digit0 to digit7 is published atomically with a one-cycle strobe.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 400000,
    parameter int CNTR_WIDTH     = 32
) (
    input  logic               clk,
    input  logic               reset,
    sevenseg_capture_if.slave  bus
);

    localparam logic [CNTR_WIDTH-1:0] L_SETTLE  = CNTR_WIDTH'(SETTLE_CYCLES);
    localparam logic [CNTR_WIDTH-1:0] L_TIMEOUT = CNTR_WIDTH'(TIMEOUT_CYCLES);

    logic [7:0]            r_an;
    logic [7:0]            r_an_q;
    logic [7:0]            r_seg;
    cap_state_t            r_state;
    cap_state_t            w_state_next;
    logic [CNTR_WIDTH-1:0] r_cnt;
    logic [CNTR_WIDTH-1:0] w_cnt_next;
    logic [CNTR_WIDTH-1:0] r_tcnt;
    logic [2:0]            r_expected;
    logic                  r_sync;
    logic                  r_publish;
    logic [7:0][4:0]       r_shadow_digits;
    logic [7:0]            r_shadow_dp;
    logic [7:0]            r_shadow_unk;
    logic [7:0][4:0]       r_digits;
    logic [7:0]            r_dp;
    logic [7:0]            r_unk;
    logic                  r_frame_valid;
    logic                  r_err_seq;
    logic                  r_stalled;

    anode_decode_t         w_an;
    logic                  w_changed;
    logic                  w_capture;
    logic                  w_in_order;
    logic                  w_write;
    logic                  w_err_order;
    logic                  w_err_invalid;
    logic                  w_publish;
    logic [6:0]            w_pattern;
    logic [4:0]            w_code;
    logic                  w_unknown;

    assign w_an          = decode_anode(r_an);
    assign w_changed     = (r_an != r_an_q);
    assign w_err_invalid = w_changed && !w_an.valid;
    assign w_in_order    = (w_an.idx == r_expected);
    assign w_write       = w_capture && (w_in_order || (w_an.idx == 3'd0));
    assign w_err_order   = w_capture && !w_in_order;
    assign w_publish     = w_capture && w_in_order && (w_an.idx == 3'd7) && r_sync;
    assign w_pattern     = ~r_seg[6:0];

    seg_pattern_decode u_decode (
        .i_pattern (w_pattern),
        .o_code    (w_code),
        .o_unknown (w_unknown)
    );

    // Register the raw display lines once and keep the previous anode for change detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an   <= 8'hFF;
            r_an_q <= 8'hFF;
            r_seg  <= 8'hFF;
        end else begin
            r_an   <= bus.an_in;
            r_an_q <= r_an;
            r_seg  <= bus.seg_in;
        end
    end

    // FSM state and settle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: an anode change always restarts settling and beats a due sample
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_an.valid) begin
                    w_state_next = SETTLE;
                    w_cnt_next   = '0;
                end
            end
            SETTLE: begin
                if (w_changed) begin
                    w_state_next = w_an.valid ? SETTLE : IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == L_SETTLE) begin
                    w_capture    = 1'b1;
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (w_changed) begin
                    w_state_next = w_an.valid ? SETTLE : IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Scan-order tracking and shadow frame; a frame only counts if it began at digit0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expected      <= 3'd0;
            r_sync          <= 1'b0;
            r_publish       <= 1'b0;
            r_shadow_digits <= {8{CODE_BLANK}};
            r_shadow_dp     <= 8'h00;
            r_shadow_unk    <= 8'h00;
        end else begin
            r_publish <= w_publish;
            if (w_write) begin
                r_shadow_digits[w_an.idx] <= w_code;
                r_shadow_dp[w_an.idx]     <= ~r_seg[7];
                r_shadow_unk[w_an.idx]    <= w_unknown;
            end
            if (w_capture) begin
                r_expected <= w_an.idx + 3'd1;
                if (w_an.idx == 3'd0) begin
                    r_sync <= 1'b1;
                end else if (!w_in_order) begin
                    r_sync <= 1'b0;
                end
            end
        end
    end

    // Publish the completed shadow frame the cycle after digit7 lands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digits      <= {8{CODE_BLANK}};
            r_dp          <= 8'h00;
            r_unk         <= 8'h00;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= r_publish;
            if (r_publish) begin
                r_digits <= r_shadow_digits;
                r_dp     <= r_shadow_dp;
                r_unk    <= r_shadow_unk;
            end
        end
    end

    // Sequence error strobe: out-of-order capture or a freshly appearing illegal anode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_seq <= 1'b0;
        end else begin
            r_err_seq <= w_err_invalid || w_err_order;
        end
    end

    // Stall watchdog: saturating count of quiet cycles in HOLD, cleared by any anode change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt    <= '0;
            r_stalled <= 1'b0;
        end else if (w_changed) begin
            r_tcnt    <= '0;
            r_stalled <= 1'b0;
        end else if (r_state == HOLD) begin
            if (r_tcnt != L_TIMEOUT) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (r_tcnt == L_TIMEOUT - 1'b1) begin
                r_stalled <= 1'b1;
            end
        end else begin
            r_tcnt <= '0;
        end
    end

    assign bus.digits_out  = r_digits;
    assign bus.dp_out      = r_dp;
    assign bus.unknown     = r_unk;
    assign bus.frame_valid = r_frame_valid;
    assign bus.err_seq     = r_err_seq;
    assign bus.stalled     = r_stalled;

endmodule
